// File: rtl/f1_lights_seq.sv
// f1_lights_seq: F1 start-light sequencer with a built-in prescaler, a lamp FSM and an optional REACTION_TIMER_EN timer.
// Latency: a trigger is accepted on the edge it is sampled; lamp k lights k*(n_i+1) enabled edges later. All outputs are registered.
// Backpressure: none. en_i low freezes the prescaler and the sequence; a trigger that arrives while busy is dropped.
module f1_lights_seq #(
    parameter int          WIDTH      = 16,
    parameter int          NUM_LIGHTS = 8,
    parameter int          HOLD_W     = 4,
    parameter logic [15:0] SEED       = 16'h0001,
    parameter int          RT_W       = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  en_i,
    input  logic [WIDTH-1:0]      n_i,
    input  logic                  trigger_i,
    output logic [NUM_LIGHTS-1:0] data_out_o,
    output logic                  busy_o,
    output logic                  lights_out_o
`ifdef REACTION_TIMER_EN
    ,
    input  logic                  react_i,
    output logic [RT_W-1:0]       react_time_o,
    output logic                  react_valid_o,
    output logic                  jump_start_o
`endif
);

    if (NUM_LIGHTS < 2 || NUM_LIGHTS > 32) begin : g_bad_num_lights
        $error("f1_lights_seq: NUM_LIGHTS must be in 2..32");
    end
    if (HOLD_W < 1 || HOLD_W > 16 || RT_W < 1) begin : g_bad_widths
        $error("f1_lights_seq: HOLD_W must be in 1..16 and RT_W at least 1");
    end
    if (SEED == 16'h0000) begin : g_bad_seed
        $error("f1_lights_seq: SEED must be nonzero");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      count_q, count_d;
    logic [NUM_LIGHTS-1:0] data_q, data_d;
    logic [HOLD_W-1:0]     hold_q, hold_d;
    logic [HOLD_W-1:0]     hold_seed;
    logic [15:0]           lfsr_q, lfsr_d;
    logic                  lights_q, lights_d;
    logic                  busy_q, busy_d;
    logic                  tick;
    logic                  accept;

    assign tick   = en_i && (count_q == '0);
    assign accept = (state_q == IDLE) && trigger_i && en_i;

    // Polynomial x^16+x^14+x^13+x^11+1. The LFSR free-runs, so the hold length depends on the trigger timing.
    assign lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    assign hold_seed = (lfsr_q[HOLD_W-1:0] == '0) ? HOLD_W'(1) : lfsr_q[HOLD_W-1:0];

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        data_d   = data_q;
        hold_d   = hold_q;
        lights_d = 1'b0;

        if (tick) begin
            count_d = n_i;
        end else if (en_i) begin
            count_d = count_q - WIDTH'(1);
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = FILL;
                    count_d = n_i;
                    data_d  = '0;
                end
            end
            FILL: begin
                if (tick) begin
                    data_d = {data_q[NUM_LIGHTS-2:0], 1'b1};
                    if (&data_q[NUM_LIGHTS-2:0]) begin
                        state_d = HOLD;
                        hold_d  = hold_seed;
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    if (hold_q == HOLD_W'(1)) begin
                        data_d   = '0;
                        lights_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        hold_d = hold_q - HOLD_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                data_d  = '0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            count_q  <= '0;
            data_q   <= '0;
            hold_q   <= '0;
            lfsr_q   <= SEED;
            lights_q <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            data_q   <= data_d;
            hold_q   <= hold_d;
            lfsr_q   <= lfsr_d;
            lights_q <= lights_d;
            busy_q   <= busy_d;
        end
    end

    assign data_out_o   = data_q;
    assign busy_o       = busy_q;
    assign lights_out_o = lights_q;

`ifdef REACTION_TIMER_EN
    logic [RT_W-1:0] rt_q, rt_d;
    logic [RT_W-1:0] rtime_q, rtime_d;
    logic            run_q, run_d;
    logic            rvld_q, rvld_d;
    logic            jump_q, jump_d;

    // The timer reads 0 in the lights_out cycle, so the captured value is the reaction delay in clk cycles.
    always_comb begin
        rt_d    = rt_q;
        run_d   = run_q;
        rtime_d = rtime_q;
        rvld_d  = 1'b0;
        jump_d  = jump_q;

        if (run_q && (rt_q != '1)) begin
            rt_d = rt_q + RT_W'(1);
        end
        if (run_q && react_i) begin
            rvld_d  = 1'b1;
            rtime_d = rt_q;
            run_d   = 1'b0;
        end
        if ((state_q != IDLE) && react_i) begin
            jump_d = 1'b1;
        end
        if (accept) begin
            run_d  = 1'b0;
            jump_d = 1'b0;
        end
        if (lights_d) begin
            rt_d  = '0;
            run_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rt_q    <= '0;
            rtime_q <= '0;
            run_q   <= 1'b0;
            rvld_q  <= 1'b0;
            jump_q  <= 1'b0;
        end else begin
            rt_q    <= rt_d;
            rtime_q <= rtime_d;
            run_q   <= run_d;
            rvld_q  <= rvld_d;
            jump_q  <= jump_d;
        end
    end

    assign react_time_o  = rtime_q;
    assign react_valid_o = rvld_q;
    assign jump_start_o  = jump_q;
`endif

endmodule

// File: tb/tb_f1_lights_seq.sv
// Bench for f1_lights_seq: directed scenarios followed by random en/trigger/n traffic.
// Expected values come from a timeline model that counts enabled edges since the trigger was accepted.
module tb_f1_lights_seq;
    localparam int          WIDTH  = 16;
    localparam int          NL     = 8;
    localparam int          HOLD_W = 4;
    localparam int          RT_W   = 16;
    localparam logic [15:0] SEED   = 16'hACE1;

    logic              clk   = 1'b0;
    logic              rst_n = 1'b1;
    logic              en    = 1'b0;
    logic [WIDTH-1:0]  n     = '0;
    logic              trigger = 1'b0;
    logic [NL-1:0]     data_out;
    logic              busy;
    logic              lights_out;
`ifdef REACTION_TIMER_EN
    logic              react = 1'b0;
    logic [RT_W-1:0]   react_time;
    logic              react_valid;
    logic              jump_start;
`endif

    int checks   = 0;
    int failures = 0;

    // Model state: position of the run, measured in enabled edges since the trigger was accepted.
    logic [15:0] m_lfsr = SEED;
    bit          m_busy = 1'b0;
    bit          m_lo   = 1'b0;
    int          m_cnt  = 0;
    int          m_n    = 0;
    int          m_hold = 0;

    f1_lights_seq #(
        .WIDTH(WIDTH), .NUM_LIGHTS(NL), .HOLD_W(HOLD_W), .SEED(SEED), .RT_W(RT_W)
    ) dut (
        .clk_i(clk),
        .rst_ni(rst_n),
        .en_i(en),
        .n_i(n),
        .trigger_i(trigger),
        .data_out_o(data_out),
        .busy_o(busy),
        .lights_out_o(lights_out)
`ifdef REACTION_TIMER_EN
        ,
        .react_i(react),
        .react_time_o(react_time),
        .react_valid_o(react_valid),
        .jump_start_o(jump_start)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] lfsr_next(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    function automatic logic [NL-1:0] exp_data();
        int k;
        logic [63:0] one;
        if (!m_busy) return '0;
        k = m_cnt / (m_n + 1);
        if (k > NL) k = NL;
        one = 64'd1;
        return NL'((one << k) - 64'd1);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        logic [15:0] smp;
        smp    = m_lfsr;
        m_lfsr = lfsr_next(m_lfsr);
        m_lo   = 1'b0;
        if (!m_busy) begin
            if (trigger && en) begin
                m_busy = 1'b1;
                m_cnt  = 0;
                m_n    = int'(n);
                m_hold = 0;
            end
        end else if (en) begin
            m_cnt++;
            if (m_cnt == NL * (m_n + 1)) begin
                m_hold = int'(smp[HOLD_W-1:0]);
                if (m_hold == 0) m_hold = 1;
            end
            if (m_cnt == (NL + m_hold) * (m_n + 1)) begin
                m_busy = 1'b0;
                m_lo   = 1'b1;
            end
        end
    endtask

    task automatic model_reset();
        m_lfsr = SEED;
        m_busy = 1'b0;
        m_lo   = 1'b0;
        m_cnt  = 0;
        m_hold = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        chk("cyc_data", 64'(data_out), 64'(exp_data()));
        chk("cyc_busy", 64'(busy), 64'(m_busy));
        chk("cyc_lo", 64'(lights_out), 64'(m_lo));
    endtask

    task automatic run_to_lo(input string tag, output int edges);
        bit seen;
        seen  = 1'b0;
        edges = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            cyc();
            edges++;
            if (lights_out) seen = 1'b1;
        end
        chk(tag, 64'(seen), 64'd1);
    endtask

    initial begin
        int e;
        int allon;
        int obs_hold;
        bit seen;

        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_data", 64'(data_out), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_lo", 64'(lights_out), 64'd0);
        chk("rst_lfsr", 64'(dut.lfsr_q), 64'(SEED));
        rst_n = 1'b1;
        model_reset();

        // One-cycle trigger with n=3: lamp k at edge 4k, blanking 4*hold edges after all-on.
        en = 1'b1; n = 16'd3; trigger = 1'b1;
        cyc();
        trigger = 1'b0;
        seen = 1'b0;
        e = 0;
        for (int i = 1; i <= 200 && !seen; i++) begin
            cyc();
            if (i == 4) chk("t2_lamp1", 64'(data_out), 64'h01);
            if (i == 8) chk("t2_lamp2", 64'(data_out), 64'h03);
            if (i == 32) chk("t2_allon", 64'(data_out), 64'hFF);
            if (lights_out) begin
                seen = 1'b1;
                e = i;
            end
        end
        chk("t2_done", 64'(seen), 64'd1);
        chk("t2_lo_edge", 64'(e), 64'(32 + 4 * m_hold));
        chk("t2_blank", 64'(data_out), 64'd0);

        // n=0 with en low for 5 cycles after lamp 3.
        n = 16'd0; trigger = 1'b1;
        cyc();
        trigger = 1'b0;
        for (int i = 0; i < 3; i++) cyc();
        chk("t3_lamp3", 64'(data_out), 64'h07);
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("t3_frozen", 64'(data_out), 64'h07);
        end
        en = 1'b1;
        run_to_lo("t3_done", e);
        chk("t3_len", 64'(e + 8), 64'(NL + m_hold + 5));

        // Asynchronous reset in the middle of FILL clears outputs without waiting for a clock.
        n = 16'd3; trigger = 1'b1;
        cyc();
        trigger = 1'b0;
        for (int i = 0; i < 10; i++) cyc();
        chk("t1_midfill", 64'(data_out), 64'h03);
        #2 rst_n = 1'b0;
        #1;
        chk("t1_data", 64'(data_out), 64'd0);
        chk("t1_busy", 64'(busy), 64'd0);
        chk("t1_lo", 64'(lights_out), 64'd0);
        chk("t1_lfsr", 64'(dut.lfsr_q), 64'(SEED));
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;

        // 50 back-to-back runs with trigger held high, n=1.
        n = 16'd1; trigger = 1'b1;
        for (int r = 0; r < 50; r++) begin
            allon = 0;
            seen  = 1'b0;
            for (int i = 0; i < 400 && !seen; i++) begin
                cyc();
                if (data_out == 8'hFF) allon++;
                if (lights_out) seen = 1'b1;
            end
            chk("t4_done", 64'(seen), 64'd1);
            obs_hold = allon / 2;
            chk("t4_hold", 64'(obs_hold), 64'(m_hold));
            chk("t4_range", 64'(obs_hold >= 1 && obs_hold <= 15), 64'd1);
            cyc();
            chk("t5_restart", 64'(busy), 64'd1);
        end
        trigger = 1'b0;
        run_to_lo("t5_drain", e);

`ifdef REACTION_TIMER_EN
        // React 10 cycles after lights_out, then a jump start during HOLD.
        n = 16'd0; trigger = 1'b1;
        cyc();
        trigger = 1'b0;
        run_to_lo("t6_run", e);
        for (int i = 0; i < 10; i++) cyc();
        react = 1'b1;
        cyc();
        react = 1'b0;
        chk("t6_rvld", 64'(react_valid), 64'd1);
        chk("t6_rtime", 64'(react_time), 64'd10);
        chk("t6_nojump", 64'(jump_start), 64'd0);
        cyc();
        chk("t6_rvld_pulse", 64'(react_valid), 64'd0);
        trigger = 1'b1;
        cyc();
        trigger = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            cyc();
            if (data_out == 8'hFF) seen = 1'b1;
        end
        chk("t6_reach_hold", 64'(seen), 64'd1);
        react = 1'b1;
        cyc();
        react = 1'b0;
        chk("t6_jump", 64'(jump_start), 64'd1);
        if (!lights_out) run_to_lo("t6_jrun", e);
        chk("t6_jump_held", 64'(jump_start), 64'd1);
        trigger = 1'b1;
        cyc();
        trigger = 1'b0;
        chk("t6_jump_clr", 64'(jump_start), 64'd0);
        run_to_lo("t6_drain", e);
`endif

        // Random en/trigger/n traffic checked cycle by cycle against the model.
        for (int i = 0; i < 3000; i++) begin
            en      = ($urandom_range(0, 9) != 0);
            trigger = ($urandom_range(0, 7) == 0);
            if (!m_busy) n = WIDTH'($urandom_range(0, 3));
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
